// File: rtl/stacker_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stacker_pkg : shared types and defaults for the stacker front end |
// | Revision    : 1.0                                                 |
// +------------------------------------------------------------------+
package stacker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_LOCKOUT = 2'd2
  } sched_state_t;

  localparam int unsigned c_debounce_cycles_dflt = 16;
  localparam int unsigned c_lockout_cycles_dflt  = 8;

  // Width of a button index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_filter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btn_filter : synchronizer, stability-counter debounce, press pulse |
// | Revision   : 1.0                                                   |
// +------------------------------------------------------------------+
module btn_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic m_clock,
  input  logic m_reset_n,
  input  logic btn_n,
  output logic hold,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_hold;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_flip;

  assign w_differ = (~r_sync2) ^ r_hold;
  assign w_flip   = w_differ && (r_cnt == c_cnt_last);

  always_ff @(posedge m_clock or negedge m_reset_n) begin
    if (!m_reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_cnt   <= '0;
      r_hold  <= 1'b0;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
      if (!w_differ || w_flip) r_cnt <= '0;
      else                     r_cnt <= r_cnt + CNT_W'(1);
      if (w_flip) r_hold <= ~r_hold;
    end
  end

  // Asserted in the cycle whose closing edge raises hold, so the
  // pending flag is set on the same edge as the filtered level.
  assign press = w_flip & ~r_hold;
  assign hold  = r_hold;

endmodule
`default_nettype wire

// File: rtl/button_event_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | button_event_scheduler : debounced buttons to one arbitrated,      |
// |   rate-limited valid/ready event channel                           |
// | Revision : 1.0                                                     |
// +------------------------------------------------------------------+
module button_event_scheduler
  import stacker_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_dflt,
  parameter int unsigned LOCKOUT_CYCLES  = c_lockout_cycles_dflt
) (
  input  logic                            m_clock,
  input  logic                            m_reset_n,
  input  logic [NUM_BTN-1:0]              m_buttons,
  output logic [NUM_BTN-1:0]              m_hold,
  output logic                            ev_valid,
  output logic [id_width(NUM_BTN)-1:0]    ev_id,
  input  logic                            ev_ready,
  output logic                            overflow,
  input  logic                            clr_overflow
);

  localparam int unsigned ID_W   = id_width(NUM_BTN);
  localparam int unsigned LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LOCK_W-1:0]  c_lock_load = LOCK_W'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);
  localparam logic [NUM_BTN-1:0] c_one       = NUM_BTN'(1);

  sched_state_t        r_state, w_state_nxt;
  logic [NUM_BTN-1:0]  r_pending, w_pending_nxt;
  logic [ID_W-1:0]     r_rr_ptr, w_rr_nxt;
  logic [ID_W-1:0]     r_ev_id, w_id_nxt;
  logic [LOCK_W-1:0]   r_lock_cnt, w_lock_nxt;
  logic                r_overflow, w_ovf_nxt;
  logic [NUM_BTN-1:0]  w_press;
  logic [NUM_BTN-1:0]  w_grant_vec;
  logic                w_sel_found;
  logic [NUM_BTN-1:0]  w_sel_vec;
  logic [ID_W-1:0]     w_sel_id;
  logic [ID_W-1:0]     w_sel_rr;
  int                  w_idx;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
      btn_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_filter (
        .m_clock   (m_clock),
        .m_reset_n (m_reset_n),
        .btn_n     (m_buttons[gi]),
        .hold      (m_hold[gi]),
        .press     (w_press[gi])
      );
    end
  endgenerate

  // Round-robin search: first pending bit at or above rr_ptr, wrapping.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_vec   = '0;
    w_sel_id    = '0;
    w_sel_rr    = '0;
    w_idx       = 0;
    for (int k = 0; k < int'(NUM_BTN); k++) begin
      w_idx = (int'(r_rr_ptr) + k) % int'(NUM_BTN);
      if (!w_sel_found && |(r_pending & (c_one << w_idx))) begin
        w_sel_found = 1'b1;
        w_sel_vec   = c_one << w_idx;
        w_sel_id    = ID_W'(w_idx);
        w_sel_rr    = ID_W'((w_idx + 1) % int'(NUM_BTN));
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_ev_id;
    w_rr_nxt    = r_rr_ptr;
    w_lock_nxt  = r_lock_cnt;
    w_grant_vec = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_found) begin
          w_state_nxt = ST_PRESENT;
          w_id_nxt    = w_sel_id;
          w_rr_nxt    = w_sel_rr;
          w_grant_vec = w_sel_vec;
        end
      end
      ST_PRESENT: begin
        if (ev_ready) begin
          if (LOCKOUT_CYCLES == 0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_LOCKOUT;
            w_lock_nxt  = c_lock_load;
          end
        end
      end
      ST_LOCKOUT: begin
        if (r_lock_cnt == '0) w_state_nxt = ST_IDLE;
        else                  w_lock_nxt  = r_lock_cnt - LOCK_W'(1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A press coinciding with its own grant re-arms the flag without overflow.
    w_pending_nxt = (r_pending & ~w_grant_vec) | w_press;
    w_ovf_nxt     = (|(w_press & r_pending & ~w_grant_vec)) | (r_overflow & ~clr_overflow);
  end

  always_ff @(posedge m_clock or negedge m_reset_n) begin
    if (!m_reset_n) begin
      r_state    <= ST_IDLE;
      r_pending  <= '0;
      r_rr_ptr   <= '0;
      r_ev_id    <= '0;
      r_lock_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_ev_id    <= w_id_nxt;
      r_lock_cnt <= w_lock_nxt;
      r_overflow <= w_ovf_nxt;
    end
  end

  assign ev_valid = (r_state == ST_PRESENT);
  assign ev_id    = r_ev_id;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
- Front-end input controller for the stacker game.
- Takes NUM_BTN raw active-low push-buttons and filters each one with a stability counter.
- Converts each debounced press into a single queued event, then shares one event channel to the game FSM with round-robin arbitration and a valid/ready handshake.
- Enforces a post-accept lockout so the game logic sees at most one event per LOCKOUT_CYCLES.

Parameters:
- NUM_BTN, 4, number of button inputs (2..8).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to change filtered state (2..1023).
- LOCKOUT_CYCLES, 8, cycles after an accepted event during which no new event is presented (0 disables).

Ports:
- m_clock  input  1  system clock.
- m_reset_n  input  1  asynchronous active-low reset.
- m_buttons  input  NUM_BTN  raw buttons, 0 = pressed, asynchronous to m_clock.
- m_hold  output  NUM_BTN  filtered level per button, 1 = pressed.
- ev_valid  output  1  event available.
- ev_id  output  $clog2(NUM_BTN)  index of button for presented event.
- ev_ready  input  1  consumer accepts event when ev_valid & ev_ready.
- overflow  output  1  sticky: a press was dropped because that button's event was still pending.
- clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Interface: one clock, m_clock. Reset m_reset_n is asynchronous and active-low.
- Reset values:
  - m_hold = 0, ev_valid = 0, ev_id = 0, overflow = 0.
  - All pending flags 0, round-robin pointer 0, lockout counter 0.
  - Synchronizer flops reset to 1 (released).
  - Per-channel counters 0.
- Per channel, implemented in the sub-module:
  - 2-flop synchronizer on ~m_buttons[i].
  - Counter increments while the synced value differs from m_hold[i] and clears to 0 when they are equal.
  - When counter == DEBOUNCE_CYCLES-1 and the value still differs: m_hold[i] toggles on that edge and the counter clears.
  - Latency: raw change to m_hold change = 2 + DEBOUNCE_CYCLES rising edges.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles produces no change.
- Press event: a one-cycle internal strobe on the edge where m_hold[i] goes 0->1. A release generates no event.
- Pending flags:
  - The strobe sets pending[i].
  - If pending[i] is already 1 and is not granted in the same cycle, overflow is set and the new press is dropped.
  - If a strobe and a grant of channel i coincide, pending[i] stays 1 and no overflow is raised.
- Output register states: IDLE (ev_valid=0), PRESENT (ev_valid=1), LOCKOUT (ev_valid=0, counting).
  - IDLE -> PRESENT: when any pending bit is set.
    - Grant the first set bit searching from rr_ptr upward, with wrap-around.
    - Load ev_id, clear that pending bit, set rr_ptr = granted+1 mod NUM_BTN.
    - ev_valid rises on the edge after the pending bit is set.
  - PRESENT: ev_valid and ev_id are held stable until ev_valid & ev_ready.
  - On accept: go to LOCKOUT with counter = LOCKOUT_CYCLES-1, or to IDLE if LOCKOUT_CYCLES = 0.
    - No back-to-back grant on the accept edge.
  - LOCKOUT: decrement each cycle; at 0 go to IDLE. Pending bits keep accumulating during lockout.
- ev_ready while ev_valid = 0 is ignored.
- clr_overflow clears overflow on the next edge. A simultaneous new overflow wins, so overflow stays 1.
- Reset asserted mid-operation: all state returns to reset values immediately. Pending events are discarded.

Decomposition:
- Shared package `stacker_pkg`:
  - Scheduler state enum (IDLE, PRESENT, LOCKOUT).
  - Default constants for DEBOUNCE_CYCLES and LOCKOUT_CYCLES.
  - A width helper for ev_id.
- One sub-module `btn_filter`, instantiated NUM_BTN times.
  - Contains the synchronizer, stability counter, m_hold level and press strobe.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- Arbiter, pending flags and lockout counter stay in the top module.

Test Plan (bench uses NUM_BTN=4, DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=3):
- Reset, then drive button 2 low and hold with ev_ready=1 -> m_hold[2] rises 6 edges after the change; ev_valid=1 with ev_id=2 on edge 7 for exactly one cycle; no further event while held.
- Pulse button 1 low for 3 synced cycles -> m_hold and ev_valid stay 0.
- Press buttons 0 and 3 in the same cycle with ev_ready=1 and rr_ptr=0 -> ev_id=0 presented, 3 idle cycles of lockout, then ev_id=3 presented.
- ev_ready=0 while ev_id=1 is presented for 20 cycles -> ev_valid and ev_id stay constant; accept on cycle 21 -> ev_valid drops on the next edge.
- With ev_ready=0, button 1's event presented and button 0 pending, press and release button 0 again -> overflow=1; only one ev_id=0 is later delivered; assert clr_overflow -> overflow=0 on the next edge.
- Assert m_reset_n=0 while in PRESENT with 2 bits pending -> ev_valid=0, overflow=0 asynchronously; after release no stale events appear.
